wkup_bus_arbiter: RTL
=====================

Name: wkup_bus_arbiter

Overview:
- Shares the two wakeup/forward result buses among N_REQ execution-unit requesters.
- These are the buses that feed operand forwarding at IQ issue.
- Each cycle it selects up to two requesters by round-robin, handshakes them with valid/ready, and drives registered bus outputs.
- Bus outputs carry valid, destination tag, data and a one-hot source.

Parameters:
- N_REQ, 4, number of requesting units (min 2).
- TAG_W, 6, physical register tag width.
- DATA_W, 32, result data width (word_t).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-high (asserted when 1).
- flush  in  1  pipeline flush.
- req_valid_i  in  N_REQ  requester i holds a result to broadcast.
- req_tag_i  in  N_REQ x TAG_W  destination tag per requester.
- req_data_i  in  N_REQ x DATA_W  result data per requester.
- req_ready_o  out  N_REQ  grant; a transfer occurs when valid and ready are both high.
- wkup_valid_o  out  2  bus b carries a result this cycle.
- wkup_tag_o  out  2 x TAG_W  bus tag.
- wkup_data_o  out  2 x DATA_W  bus data.
- wkup_src_o  out  2 x N_REQ  one-hot source requester per bus.
- rr_ptr_o  out  clog2(N_REQ)  current round-robin start index (debug/verification).

Behaviour:
- State:
  - rr_ptr, clog2(N_REQ) bits.
  - One output register set per bus: valid, tag, data, src.
- Arbitration (combinational):
  - Scan indices rr_ptr, rr_ptr+1, ... mod N_REQ.
  - First valid requester found goes to bus 0, second to bus 1.
  - Fewer than two valid requesters: unused bus gets no grant.
  - A requester never receives both buses.
- req_ready_o[i] = 1 iff i is granted this cycle and flush = 0 and rst_n = 0. It is combinational from req_valid_i and rr_ptr only.
- Requester contract: tag/data held stable while valid and not ready. Valid is not dropped before handshake, except on flush.
- Latency: a handshake in cycle t appears on the bus outputs in cycle t+1. Bus outputs are registered.
- Idle bus: in any cycle where bus b has no grant, next-cycle wkup_valid_o[b] = 0 and its tag, data and src are all driven zero. Consumers OR-combine buses, so invalid buses must be zero.
- rr_ptr update on a cycle with at least one handshake: rr_ptr <= (index of the last granted requester + 1) mod N_REQ. No handshake: rr_ptr holds.
- Fairness: a continuously-valid requester is granted within ceil(N_REQ/2) cycles.
- flush = 1:
  - No grants.
  - All bus outputs cleared to zero the next cycle.
  - rr_ptr holds.
  - Requesters are expected to drop valid themselves.
- Reset (rst_n = 1):
  - rr_ptr = 0.
  - All outputs zero: wkup_valid_o = 0, tag/data/src = 0, req_ready_o = 0.
  - Reset dominates flush and any request.
  - Reset mid-handshake discards the in-flight grant; nothing is broadcast the following cycle.
- Wrap-around: the scan wraps from N_REQ-1 to 0. The rr_ptr increment wraps mod N_REQ, including for non-power-of-2 N_REQ.
- Same tag on two requesters: both are broadcast as-is. Tag uniqueness is the rename stage's responsibility.

Test Plan:
- Reset then idle: rst_n = 1 for 2 cycles, then 0 with no requests -> all outputs 0, rr_ptr_o = 0 throughout.
- Single requester: req_valid_i = 4'b0100, tag 0x15, data 0xDEADBEEF -> ready[2] same cycle; next cycle bus0 valid, tag 0x15, data 0xDEADBEEF, src 4'b0100; bus1 all zero; rr_ptr_o = 3.
- All four valid continuously from rr_ptr = 0 -> cycle 0 grants 0 (bus0) and 1 (bus1), rr_ptr = 2; cycle 1 grants 2 and 3, rr_ptr = 0; pattern repeats, no requester waits more than 2 cycles.
- Wrap: rr_ptr = 3, req_valid_i = 4'b1001 -> bus0 = req3, bus1 = req0, new rr_ptr = 1.
- Flush: requests 4'b0011 with flush = 1 -> req_ready_o = 0; next cycle both buses invalid and zero; rr_ptr unchanged.
- Backpressure hold: req 0, 1, 2 valid, rr_ptr = 0 -> req2 not ready and holds data 0x12345678; next cycle req2 granted on bus0; bus data matches the held value.

Source files
------------

// File: rtl/wkup_bus_arbiter.sv
// Round-robin arbiter sharing the two wakeup/forward buses among N_REQ units.
// Picks up to two requesters per cycle and drives registered bus outputs.
module wkup_bus_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int TAG_W  = 6,
    parameter  int DATA_W = 32,
    localparam int PTR_W  = $clog2(N_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [N_REQ-1:0]                 req_valid_i,
    input  logic [N_REQ-1:0][TAG_W-1:0]      req_tag_i,
    input  logic [N_REQ-1:0][DATA_W-1:0]     req_data_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    output logic [1:0]                       wkup_valid_o,
    output logic [1:0][TAG_W-1:0]            wkup_tag_o,
    output logic [1:0][DATA_W-1:0]           wkup_data_o,
    output logic [1:0][N_REQ-1:0]            wkup_src_o,
    output logic [PTR_W-1:0]                 rr_ptr_o
);

    logic [PTR_W-1:0]            rr_ptr;
    logic [PTR_W-1:0]            scan_idx [N_REQ];
    logic [1:0]                  hit;
    logic [1:0][PTR_W-1:0]       sel;
    logic [1:0]                  take;
    logic [1:0][N_REQ-1:0]       oh;
    logic [PTR_W-1:0]            last;
    logic                        grant_en;

    // (base + k) mod N_REQ, valid for any N_REQ including non-powers of 2
    function automatic logic [PTR_W-1:0] idx_at(
        input logic [PTR_W-1:0] base,
        input int unsigned      k
    );
        logic [PTR_W:0] s;
        s = {1'b0, base} + (PTR_W+1)'(k);
        if (s >= (PTR_W+1)'(N_REQ))
            s = s - (PTR_W+1)'(N_REQ);
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < N_REQ; k++)
            scan_idx[k] = idx_at(rr_ptr, k);
    end

    always_comb begin
        hit = '0;
        sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (req_valid_i[scan_idx[k]]) begin
                if (!hit[0]) begin
                    hit[0] = 1'b1;
                    sel[0] = scan_idx[k];
                end else if (!hit[1]) begin
                    hit[1] = 1'b1;
                    sel[1] = scan_idx[k];
                end
            end
        end
    end

    assign grant_en = !rst_n && !flush;
    assign take     = hit & {2{grant_en}};
    assign last     = take[1] ? sel[1] : sel[0];

    always_comb begin
        oh = '0;
        for (int b = 0; b < 2; b++)
            if (take[b])
                oh[b] = N_REQ'(1) << sel[b];
    end

    assign req_ready_o = oh[0] | oh[1];
    assign rr_ptr_o    = rr_ptr;

    // Idle buses are forced to zero: consumers OR the two buses together
    always_ff @(posedge clk) begin
        if (rst_n) begin
            rr_ptr       <= '0;
            wkup_valid_o <= '0;
            wkup_tag_o   <= '0;
            wkup_data_o  <= '0;
            wkup_src_o   <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                wkup_valid_o[b] <= take[b];
                wkup_src_o[b]   <= oh[b];
                wkup_tag_o[b]   <= take[b] ? req_tag_i[sel[b]]  : '0;
                wkup_data_o[b]  <= take[b] ? req_data_i[sel[b]] : '0;
            end
            if (take[0])
                rr_ptr <= idx_at(last, 1);
        end
    end

endmodule
